mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the memory word-address width.
REQ-002 The block SHALL have parameter I_ADDR_W, default 14, meaning the instruction word-address width, zero-extended to ADDR_W.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port i_req, input, 1 bit: instruction fetch request.
REQ-006 The block SHALL have port i_addr, input, I_ADDR_W bits: fetch word address.
REQ-007 The block SHALL have port i_gnt, output, 1 bit: fetch accepted this cycle.
REQ-008 The block SHALL have ports i_rvalid and i_rdata, output, 1 and 32 bits: fetch data return.
REQ-009 The block SHALL have port d_req, input, 1 bit: data access request.
REQ-010 The block SHALL have ports d_we, d_wstrb, d_addr and d_wdata, input, 1, 4, ADDR_W and 32 bits: data write flag, write byte strobes, word address and write data.
REQ-011 The block SHALL have port d_gnt, output, 1 bit: data access accepted this cycle.
REQ-012 The block SHALL have ports d_rvalid and d_rdata, output, 1 and 32 bits: load data return.
REQ-013 The block SHALL have ports mem_en, mem_we, mem_addr and mem_wdata, output, 1, 4, ADDR_W and 32 bits: the single shared synchronous-read memory port.
REQ-014 The block SHALL have port mem_rdata, input, 32 bits: memory read data, valid one cycle after a read is issued.
REQ-015 The block SHALL have ports i_stall and d_stall, output, 1 bit each: stall to the hazard unit, equal to req AND NOT gnt.
REQ-016 The block SHALL have port conflict_cnt, output, 16 bits: saturating count of cycles with both requests asserted.

Function
REQ-017 Grants SHALL be combinational in the request cycle; at most one of i_gnt and d_gnt SHALL be high in any cycle.
REQ-018 If only one requester is active, that requester SHALL be granted.
REQ-019 If both are active, arbitration SHALL be round-robin using register last_gnt: the requester not granted last wins; after reset last_gnt SHALL be INSTR, so data wins the first conflict.
REQ-020 last_gnt SHALL update only on a cycle with a grant.
REQ-021 On a grant, mem_en SHALL be 1 and mem_addr SHALL be the granted address.
REQ-022 mem_we SHALL equal d_wstrb when data is granted and d_we is 1, and 4'b0000 otherwise.
REQ-023 mem_wdata SHALL equal d_wdata.
REQ-024 Read response tracking SHALL use an FSM with states IDLE, I_PEND and D_PEND, advancing every cycle.
REQ-025 The next state SHALL be I_PEND after an instruction grant, D_PEND after a data read grant, and IDLE after a data write or no grant.
REQ-026 In I_PEND, i_rvalid SHALL be 1; in D_PEND, d_rvalid SHALL be 1; each rvalid SHALL be a single-cycle pulse with latency exactly 1.
REQ-027 i_rdata and d_rdata SHALL both be driven from mem_rdata; data SHALL be qualified only by the matching rvalid.
REQ-028 Back-to-back grants SHALL be fully pipelined with no bubble; throughput is 1 access per cycle.
REQ-029 Writes SHALL never produce rvalid.
REQ-030 conflict_cnt SHALL increment when i_req and d_req are both 1, and SHALL hold at 16'hFFFF.

Reset
REQ-031 While rst_n is 0 at a clock edge, the FSM SHALL go to IDLE, last_gnt SHALL go to INSTR, and conflict_cnt SHALL go to 0.
REQ-032 While rst_n is 0, all grant, rvalid, mem_en and mem_we outputs SHALL be forced to 0, and stall outputs SHALL be 0.
REQ-033 A read in flight when reset is asserted SHALL be discarded: no rvalid SHALL pulse in the cycle after reset.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum (IDLE/I_PEND/D_PEND), the owner enum (INSTR/DATA) and the counter width constant.
REQ-035 The block SHALL instantiate one sub-module, arb_rr2: a two-input round-robin arbiter with last_gnt state.
REQ-036 The remaining logic (port mux, FSM and counter) SHALL stay in mem_arbiter.

Verification
REQ-037 Scenario 1: i_req=1, i_addr=0x10, d_req=0 -> i_gnt=1, mem_addr=0x0010, mem_we=0; next cycle i_rvalid=1 and i_rdata=mem_rdata.
REQ-038 Scenario 2: after reset, both requests with d_we=0 and d_addr=0x20 -> cycle 0 d_gnt=1 and i_stall=1; cycle 1 i_gnt=1 and d_rvalid=1; cycle 2 i_rvalid=1; conflict_cnt=1.
REQ-039 Scenario 3: data write with d_wstrb=4'b0011 and d_wdata=0xDEADBEEF -> mem_we=4'b0011 and mem_wdata=0xDEADBEEF; no rvalid the next cycle.
REQ-040 Scenario 4: both requests held for 6 cycles -> grants alternate D,I,D,I,D,I; conflict_cnt=6; each rvalid lags its grant by exactly 1 cycle.
REQ-041 Scenario 5: i_gnt issued, then rst_n=0 on the next edge -> i_rvalid stays 0 and all outputs are 0 during reset.
REQ-042 Scenario 6: force conflict_cnt to 0xFFFE, then 3 conflict cycles -> conflict_cnt=0xFFFF and holds.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Defines the response-tracking states, the grant owner and the conflict counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_PEND,
    D_PEND
  } state_e;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_e;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin arbiter (instruction vs data) with a last-grant register.
// Grants are combinational; on a conflict the requester not granted last wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic i_gnt_o,
  output logic d_gnt_o
);

  owner_e last_gnt_q, last_gnt_d;

  always_comb begin
    i_gnt_o    = 1'b0;
    d_gnt_o    = 1'b0;
    last_gnt_d = last_gnt_q;
    if (rst_n) begin
      if (i_req_i && d_req_i) begin
        if (last_gnt_q == INSTR) d_gnt_o = 1'b1;
        else                     i_gnt_o = 1'b1;
      end else begin
        i_gnt_o = i_req_i;
        d_gnt_o = d_req_i;
      end
      // Priority only moves on cycles that actually grant something.
      if (i_gnt_o)      last_gnt_d = INSTR;
      else if (d_gnt_o) last_gnt_d = DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_gnt_q <= INSTR;
    else        last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and data access.
// Read returns are tracked by a one-deep pending FSM; rdata is qualified by the matching rvalid.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned I_ADDR_W = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [I_ADDR_W-1:0] i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [31:0]         i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [3:0]          d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [31:0]         d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [31:0]         d_rdata,
  output logic                mem_en,
  output logic [3:0]          mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic                i_stall,
  output logic                d_stall,
  output logic [CNT_W-1:0]    conflict_cnt
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  arb_rr2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req_i (i_req),
    .d_req_i (d_req),
    .i_gnt_o (i_gnt),
    .d_gnt_o (d_gnt)
  );

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    if (i_gnt) begin
      mem_en   = 1'b1;
      mem_addr = ADDR_W'(i_addr);
    end else if (d_gnt) begin
      mem_en   = 1'b1;
      mem_addr = d_addr;
      if (d_we) mem_we = d_wstrb;
    end
  end

  assign mem_wdata = d_wdata;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign i_stall   = rst_n & i_req & ~i_gnt;
  assign d_stall   = rst_n & d_req & ~d_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state depends only on this cycle's grant, so back-to-back reads pipeline.
  always_comb begin
    state_d  = IDLE;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    if (i_gnt)                state_d = I_PEND;
    else if (d_gnt && !d_we)  state_d = D_PEND;
    case (state_q)
      I_PEND:  i_rvalid = rst_n;
      D_PEND:  d_rvalid = rst_n;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_req && d_req && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected grants/returns into queues,
// a forked monitor pops and compares them whenever the DUT presents a grant or rvalid.
module tb_mem_arbiter;

  typedef enum logic [1:0] {EN, EI, ED} ex_e;

  typedef struct {
    logic        is_d;
    logic [15:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          cyc;
  } gnt_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [13:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_wstrb;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        i_stall, d_stall;
  logic [15:0] conflict_cnt;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  gnt_t gq[$];
  rsp_t iq[$];
  rsp_t dq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(16), .I_ADDR_W(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_gnt        (i_gnt),
    .i_rvalid     (i_rvalid),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_wstrb      (d_wstrb),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .i_stall      (i_stall),
    .d_stall      (d_stall),
    .conflict_cnt (conflict_cnt)
  );

  function automatic logic [31:0] rd_model(logic [15:0] a);
    return {a ^ 16'hC3C3, ~a};
  endfunction

  // Synchronous-read memory with address-derived contents.
  always @(posedge clk)
    if (mem_en && mem_we == 4'b0000) mem_rdata <= rd_model(mem_addr);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step(logic ir, logic [13:0] ia, logic dr, logic dwe, logic [3:0] ds,
                      logic [15:0] da, logic [31:0] dw, ex_e ex);
    gnt_t g;
    rsp_t r;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_wstrb = ds; d_addr = da; d_wdata = dw;
    if (ex == EI) begin
      g = '{1'b0, {2'b00, ia}, 4'b0000, 32'h0, cyc};
      gq.push_back(g);
      r = '{rd_model({2'b00, ia}), cyc + 1};
      iq.push_back(r);
    end else if (ex == ED) begin
      g = '{1'b1, da, dwe ? ds : 4'b0000, dw, cyc};
      gq.push_back(g);
      if (!dwe) begin
        r = '{rd_model(da), cyc + 1};
        dq.push_back(r);
      end
    end
    #2;
    chk("i_stall", {31'b0, i_stall}, {31'b0, ir && ex != EI});
    chk("d_stall", {31'b0, d_stall}, {31'b0, dr && ex != ED});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 14'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, EN);
  endtask

  task automatic do_reset();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_cnt", {16'h0, conflict_cnt}, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_gnt"},    {30'b0, i_gnt, d_gnt}, 32'h0);
    chk({tag, "_rvalid"}, {30'b0, i_rvalid, d_rvalid}, 32'h0);
    chk({tag, "_mem_en"}, {31'b0, mem_en}, 32'h0);
    chk({tag, "_mem_we"}, {28'b0, mem_we}, 32'h0);
    chk({tag, "_stall"},  {30'b0, i_stall, d_stall}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_wstrb = '0; d_addr = '0; d_wdata = '0;

    fork
      forever begin
        gnt_t g;
        rsp_t r;
        @(negedge clk);
        if (i_gnt || d_gnt) begin
          if (gq.size() == 0) chk("unexpected_gnt", {30'b0, i_gnt, d_gnt}, 32'h0);
          else begin
            g = gq.pop_front();
            chk("gnt_who", {30'b0, i_gnt, d_gnt}, g.is_d ? 32'h1 : 32'h2);
            chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
            chk("mem_en", {31'b0, mem_en}, 32'h1);
            chk("mem_addr", {16'h0, mem_addr}, {16'h0, g.addr});
            chk("mem_we", {28'b0, mem_we}, {28'b0, g.we});
            if (g.is_d) chk("mem_wdata", mem_wdata, g.wdata);
          end
        end
        if (i_rvalid) begin
          if (iq.size() == 0) chk("unexpected_i_rvalid", {31'b0, i_rvalid}, 32'h0);
          else begin
            r = iq.pop_front();
            chk("i_rvalid_cycle", 32'(cyc), 32'(r.cyc));
            chk("i_rdata", i_rdata, r.data);
          end
        end
        if (d_rvalid) begin
          if (dq.size() == 0) chk("unexpected_d_rvalid", {31'b0, d_rvalid}, 32'h0);
          else begin
            r = dq.pop_front();
            chk("d_rvalid_cycle", 32'(cyc), 32'(r.cyc));
            chk("d_rdata", d_rdata, r.data);
          end
        end
      end
    join_none

    @(posedge clk); #1;
    chk_all_zero("init_rst");
    do_reset();

    // Fetch only; the return shows up on the following idle cycle.
    step(1'b1, 14'h0010, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, EI);
    idle();
    // Instruction address zero-extension at the top of the fetch range.
    step(1'b1, 14'h3FFF, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, EI);
    idle();

    // First conflict after reset goes to data.
    do_reset();
    step(1'b1, 14'h0030, 1'b1, 1'b0, 4'h0, 16'h0020, 32'h0, ED);
    step(1'b1, 14'h0030, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0, EI);
    idle();
    chk("cnt_single_conflict", {16'h0, conflict_cnt}, 32'h1);

    // Partial-strobe write, then a read with strobes set but d_we low.
    step(1'b0, 14'h0, 1'b1, 1'b1, 4'b0011, 16'h0040, 32'hDEADBEEF, ED);
    idle();
    step(1'b0, 14'h0, 1'b1, 1'b0, 4'b1111, 16'h0044, 32'h12345678, ED);
    // Back-to-back data reads with no bubble.
    step(1'b0, 14'h0, 1'b1, 1'b0, 4'h0, 16'h0050, 32'h0, ED);
    step(1'b0, 14'h0, 1'b1, 1'b0, 4'h0, 16'h0051, 32'h0, ED);
    idle();

    // Six held conflict cycles alternate D,I,D,I,D,I.
    do_reset();
    for (int k = 0; k < 6; k++)
      step(1'b1, 14'h0100, 1'b1, 1'b0, 4'h0, 16'h0200, 32'h0, (k % 2 == 0) ? ED : EI);
    idle();
    chk("cnt_six_conflicts", {16'h0, conflict_cnt}, 32'h6);

    // Reset lands while a fetch return is pending: the return is dropped.
    step(1'b1, 14'h0123, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, EI);
    void'(iq.pop_back());
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF;
    #2;
    chk_all_zero("in_rst_a");
    @(posedge clk); #1;
    chk_all_zero("in_rst_b");
    rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #2;
    chk("post_rst_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    @(posedge clk); #1;
    idle();

    // Saturation: walk the counter up to 0xFFFE, then past the ceiling.
    do_reset();
    for (int k = 0; k < 65534; k++)
      step(1'b1, 14'h0005, 1'b1, 1'b0, 4'h0, 16'h0006, 32'h0, (k % 2 == 0) ? ED : EI);
    chk("cnt_fffe", {16'h0, conflict_cnt}, 32'hFFFE);
    for (int k = 65534; k < 65537; k++)
      step(1'b1, 14'h0005, 1'b1, 1'b0, 4'h0, 16'h0006, 32'h0, (k % 2 == 0) ? ED : EI);
    chk("cnt_sat", {16'h0, conflict_cnt}, 32'hFFFF);
    step(1'b1, 14'h0007, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, EI);
    idle();
    chk("cnt_hold", {16'h0, conflict_cnt}, 32'hFFFF);

    idle();
    chk("gq_drained", 32'(gq.size()), 32'h0);
    chk("iq_drained", 32'(iq.size()), 32'h0);
    chk("dq_drained", 32'(dq.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
